// File: rtl/regfile_dump_tx.sv
// Purpose: walk a register file through its sync-read port and stream it as one framed byte stream.
// Latency: start to first byte 1 cycle with sync byte (3 without); 2 idle cycles between registers.
// Backpressure: out_valid/out_data hold until out_ready; a stall of any length loses or repeats nothing.
module regfile_dump_tx #(
    parameter int           NUM_REGS  = 32,
    parameter int           REG_WIDTH = 32,
    parameter int           ADDR_W    = 5,
    parameter bit           SYNC_EN   = 1'b1,
    parameter logic [7:0]   SYNC_BYTE = 8'hA5,
    parameter bit           CSUM_EN   = 1'b1,
    parameter bit           MSB_FIRST = 1'b0
) (
    input  logic                 clk12,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [ADDR_W-1:0]    reg_address,
    input  logic [REG_WIDTH-1:0] reg_data,
    output logic [7:0]           out_data,
    output logic                 out_valid,
    input  logic                 out_ready
);

    // Bytes per register and the width of the byte index (at least one bit).
    localparam int BPR   = REG_WIDTH / 8;
    localparam int IDX_W = (BPR > 1) ? $clog2(BPR) : 1;

    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(BPR - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

    // Frame sequencer states.
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SYNC  = 3'd1;
    localparam logic [2:0] ST_FETCH = 3'd2;
    localparam logic [2:0] ST_LOAD  = 3'd3;
    localparam logic [2:0] ST_SEND  = 3'd4;
    localparam logic [2:0] ST_CSUM  = 3'd5;

    logic [2:0]           state_q, state_d;
    logic [ADDR_W-1:0]    addr_q,  addr_d;
    logic [IDX_W-1:0]     idx_q,   idx_d;
    logic [REG_WIDTH-1:0] snap_q,  snap_d;
    logic [7:0]           csum_q,  csum_d;
    logic                 done_q,  done_d;

    logic [IDX_W-1:0]     byte_sel;
    logic [REG_WIDTH-1:0] snap_shifted;
    logic [7:0]           cur_byte;

    // Pick the current byte of the captured word; MSB_FIRST reverses the byte order.
    always_comb begin
        byte_sel     = MSB_FIRST ? (LAST_IDX - idx_q) : idx_q;
        snap_shifted = snap_q >> {byte_sel, 3'b000};
        cur_byte     = snap_shifted[7:0];
    end

    // Output byte mux: only SYNC, SEND and CSUM present a byte; everything else drives zero.
    always_comb begin
        out_valid = 1'b0;
        out_data  = 8'h00;
        case (state_q)
            ST_SYNC: begin
                out_valid = 1'b1;
                out_data  = SYNC_BYTE;
            end
            ST_SEND: begin
                out_valid = 1'b1;
                out_data  = cur_byte;
            end
            ST_CSUM: begin
                out_valid = 1'b1;
                out_data  = csum_q;
            end
            default: begin
                out_valid = 1'b0;
                out_data  = 8'h00;
            end
        endcase
    end

    // Frame sequencing: address walk, byte walk, checksum accumulation and end-of-frame cleanup.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        idx_d   = idx_q;
        snap_d  = snap_q;
        csum_d  = csum_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d  = '0;
                    idx_d   = '0;
                    csum_d  = 8'h00;
                    state_d = SYNC_EN ? ST_SYNC : ST_FETCH;
                end
            end

            ST_SYNC: begin
                // The sync byte is a marker only and is kept out of the checksum.
                if (out_ready) begin
                    state_d = ST_FETCH;
                end
            end

            ST_FETCH: begin
                // Address has been stable for this cycle; read data lands next cycle.
                state_d = ST_LOAD;
            end

            ST_LOAD: begin
                // Snapshot so later changes on reg_data cannot tear this register's bytes.
                snap_d  = reg_data;
                idx_d   = '0;
                state_d = ST_SEND;
            end

            ST_SEND: begin
                if (out_ready) begin
                    csum_d = csum_q ^ cur_byte;
                    if (idx_q != LAST_IDX) begin
                        idx_d = idx_q + 1'b1;
                    end else if (addr_q < LAST_ADDR) begin
                        addr_d  = addr_q + 1'b1;
                        state_d = ST_FETCH;
                    end else if (CSUM_EN) begin
                        state_d = ST_CSUM;
                    end else begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                        addr_d  = '0;
                        idx_d   = '0;
                        csum_d  = 8'h00;
                    end
                end
            end

            ST_CSUM: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    addr_d  = '0;
                    idx_d   = '0;
                    csum_d  = 8'h00;
                end
            end

            default: begin
                state_d = ST_IDLE;
                addr_d  = '0;
                idx_d   = '0;
                csum_d  = 8'h00;
            end
        endcase
    end

    // State registers; reset abandons any frame in flight.
    always_ff @(posedge clk12 or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            idx_q   <= '0;
            snap_q  <= '0;
            csum_q  <= 8'h00;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            csum_q  <= csum_d;
            done_q  <= done_d;
        end
    end

    assign busy        = (state_q != ST_IDLE);
    assign done        = done_q;
    assign reg_address = addr_q;

endmodule

// File: tb/tb_regfile_dump_tx.sv
module tb_regfile_dump_tx;

    localparam int NR = 4;

    logic        clk12 = 1'b0;
    logic        rst;
    logic        start_a, start_b;
    logic        busy_a, busy_b, done_a, done_b;
    logic [1:0]  addr_a, addr_b;
    logic [31:0] rd_a, rd_b;
    logic [7:0]  out_data_a, out_data_b;
    logic        out_valid_a, out_valid_b;
    logic        out_ready_a, out_ready_b;

    always #5 clk12 = ~clk12;

    logic [31:0] regs [NR];

    // Sync-read register file models, one port per DUT
    always @(posedge clk12) begin
        rd_a <= regs[addr_a];
        rd_b <= regs[addr_b];
    end

    regfile_dump_tx #(
        .NUM_REGS(4), .REG_WIDTH(32), .ADDR_W(2), .SYNC_EN(1'b1),
        .SYNC_BYTE(8'hA5), .CSUM_EN(1'b1), .MSB_FIRST(1'b0)
    ) dut (
        .clk12(clk12), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
        .reg_address(addr_a), .reg_data(rd_a), .out_data(out_data_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a)
    );

    regfile_dump_tx #(
        .NUM_REGS(4), .REG_WIDTH(32), .ADDR_W(2), .SYNC_EN(1'b1),
        .SYNC_BYTE(8'hA5), .CSUM_EN(1'b1), .MSB_FIRST(1'b1)
    ) dut_msb (
        .clk12(clk12), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
        .reg_address(addr_b), .reg_data(rd_b), .out_data(out_data_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk12) cyc <= cyc + 1;

    logic [7:0] T1_TBL [18] = '{8'hA5, 8'h44, 8'h33, 8'h22, 8'h11, 8'h00, 8'h00, 8'h00, 8'h00,
                                8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h04, 8'h03, 8'h02, 8'h01, 8'h40};
    logic [7:0] T2_TBL [18] = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00, 8'h00, 8'h00,
                                8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01, 8'h02, 8'h03, 8'h04, 8'h40};

    // Transfer monitor for the LSB-first DUT (sampled mid-cycle, before the edge that transfers)
    logic [7:0] got_q [$];
    int         xfer_cyc [$];
    int         done_cnt = 0;
    int         done_cyc = 0;
    int         stab_viol = 0;
    int         max_addr = 0;
    bit         hold_pend = 1'b0;
    logic [7:0] hold_dat = 8'h00;

    always @(negedge clk12) begin
        if (rst) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend && (out_valid_a !== 1'b1 || out_data_a !== hold_dat)) stab_viol++;
            hold_pend = out_valid_a && !out_ready_a;
            hold_dat  = out_data_a;
            if (out_valid_a && out_ready_a) begin
                got_q.push_back(out_data_a);
                xfer_cyc.push_back(cyc);
            end
            if (done_a) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (int'(addr_a) > max_addr) max_addr = int'(addr_a);
        end
    end

    // Stimulus control for the LSB-first DUT
    bit rdy_rand  = 1'b0;
    int hold_at   = -1;
    int hold_left = 0;
    int repulse [$];

    task automatic tick();
        @(posedge clk12);
        #1;
        start_a = 1'b0;
        if (hold_left > 0) begin
            out_ready_a = 1'b0;
            hold_left--;
        end else if (hold_at >= 0 && got_q.size() >= hold_at) begin
            hold_at     = -1;
            hold_left   = 39;
            out_ready_a = 1'b0;
        end else begin
            out_ready_a = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        if (repulse.size() > 0 && got_q.size() >= repulse[0]) begin
            void'(repulse.pop_front());
            start_a = 1'b1;
        end
    endtask

    task automatic wait_done(input int d0, input int budget, output bit to);
        to = 1'b1;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (done_cnt != d0) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic clear_mon();
        got_q.delete();
        xfer_cyc.delete();
        stab_viol = 0;
    endtask

    // Reference model: frame = sync, each register's bytes in the chosen order, XOR of register bytes
    logic [7:0] exp_q [$];

    task automatic build_exp(input bit msb);
        logic [7:0] cs = 8'h00;
        logic [7:0] b;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        for (int r = 0; r < NR; r++) begin
            for (int k = 0; k < 4; k++) begin
                b = 8'(regs[r] >> (msb ? (3 - k) * 8 : k * 8));
                exp_q.push_back(b);
                cs ^= b;
            end
        end
        exp_q.push_back(cs);
    endtask

    task automatic load_t1_regs();
        regs[0] = 32'h11223344;
        regs[1] = 32'h00000000;
        regs[2] = 32'hFFFFFFFF;
        regs[3] = 32'h01020304;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start_a = 1'b1;
        repeat (3) @(posedge clk12);
        @(negedge clk12);
        checks++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid_a); end
        checks++; if (out_data_a !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", out_data_a); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy (start held in reset): got %b expected 0", busy_a); end
        checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done_a); end
        checks++; if (addr_a !== 2'd0) begin errors++; $display("FAIL reset_addr: got %0d expected 0", addr_a); end
        checks++; if (out_valid_b !== 1'b0 || busy_b !== 1'b0) begin errors++; $display("FAIL reset_msb_dut: valid %b busy %b expected 0 0", out_valid_b, busy_b); end
        start_a = 1'b0;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_t1_lsb();
        int d0;
        bit to;
        int gap;
        load_t1_regs();
        rdy_rand = 1'b0;
        repeat (4) tick();
        clear_mon();
        d0 = done_cnt;
        start_a = 1'b1;
        tick();
        @(negedge clk12);
        checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL t1_busy_after_start: got %b expected 1", busy_a); end
        checks++; if (out_valid_a !== 1'b1 || out_data_a !== 8'hA5) begin errors++; $display("FAIL t1_first_byte_latency: valid %b data %h expected 1 a5", out_valid_a, out_data_a); end
        wait_done(d0, 500, to);
        checks++; if (to) begin errors++; $display("FAIL t1_timeout: no done within 500 cycles"); end
        checks++; if (got_q.size() != 18) begin errors++; $display("FAIL t1_len: got %0d expected 18", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < 18; i++) begin
            checks++; if (got_q[i] !== T1_TBL[i]) begin errors++; $display("FAIL t1_byte[%0d]: got %h expected %h", i, got_q[i], T1_TBL[i]); end
        end
        for (int i = 1; i < xfer_cyc.size() && i < 18; i++) begin
            gap = (i <= 16 && (i - 1) % 4 == 0) ? 3 : 1;
            checks++; if (xfer_cyc[i] - xfer_cyc[i-1] != gap) begin errors++; $display("FAIL t1_gap[%0d]: got %0d expected %0d", i, xfer_cyc[i] - xfer_cyc[i-1], gap); end
        end
        if (xfer_cyc.size() > 0) begin
            checks++; if (done_cyc - xfer_cyc[xfer_cyc.size()-1] != 1) begin errors++; $display("FAIL t1_done_delay: got %0d expected 1", done_cyc - xfer_cyc[xfer_cyc.size()-1]); end
        end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL t1_done_count: got %0d expected 1", done_cnt - d0); end
        checks++; if (busy_a !== 1'b0 || done_a !== 1'b0 || addr_a !== 2'd0) begin errors++; $display("FAIL t1_idle_after: busy %b done %b addr %0d expected 0 0 0", busy_a, done_a, addr_a); end
    endtask

    task automatic test_msb_first();
        logic [7:0] got_b [$];
        int n_done = 0;
        bit to = 1'b1;
        load_t1_regs();
        out_ready_b = 1'b1;
        start_b = 1'b1;
        @(posedge clk12);
        #1 start_b = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk12);
            if (out_valid_b && out_ready_b) got_b.push_back(out_data_b);
            if (done_b) begin
                n_done++;
                to = 1'b0;
                break;
            end
        end
        checks++; if (to) begin errors++; $display("FAIL t2_timeout: no done within 300 cycles"); end
        checks++; if (got_b.size() != 18) begin errors++; $display("FAIL t2_len: got %0d expected 18", got_b.size()); end
        for (int i = 0; i < got_b.size() && i < 18; i++) begin
            checks++; if (got_b[i] !== T2_TBL[i]) begin errors++; $display("FAIL t2_byte[%0d]: got %h expected %h", i, got_b[i], T2_TBL[i]); end
        end
    endtask

    task automatic test_stall();
        int d0;
        bit to;
        load_t1_regs();
        rdy_rand = 1'b1;
        hold_at  = 6;
        clear_mon();
        d0 = done_cnt;
        start_a = 1'b1;
        wait_done(d0, 2000, to);
        rdy_rand = 1'b0;
        checks++; if (to) begin errors++; $display("FAIL t3_timeout: no done within 2000 cycles"); end
        checks++; if (got_q.size() != 18) begin errors++; $display("FAIL t3_len: got %0d expected 18", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < 18; i++) begin
            checks++; if (got_q[i] !== T1_TBL[i]) begin errors++; $display("FAIL t3_byte[%0d]: got %h expected %h", i, got_q[i], T1_TBL[i]); end
        end
        checks++; if (stab_viol != 0) begin errors++; $display("FAIL t3_hold_stability: got %0d violations expected 0", stab_viol); end
    endtask

    task automatic test_repulse();
        int d0;
        bit to;
        load_t1_regs();
        rdy_rand = 1'b0;
        clear_mon();
        repulse.delete();
        repulse.push_back(3);
        repulse.push_back(10);
        d0 = done_cnt;
        start_a = 1'b1;
        wait_done(d0, 500, to);
        repeat (30) tick();
        checks++; if (to) begin errors++; $display("FAIL t4_timeout: no done within 500 cycles"); end
        checks++; if (got_q.size() != 18) begin errors++; $display("FAIL t4_len: got %0d expected 18", got_q.size()); end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL t4_done_count: got %0d expected 1", done_cnt - d0); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL t4_busy_after: got %b expected 0", busy_a); end
        for (int i = 0; i < got_q.size() && i < 18; i++) begin
            checks++; if (got_q[i] !== T1_TBL[i]) begin errors++; $display("FAIL t4_byte[%0d]: got %h expected %h", i, got_q[i], T1_TBL[i]); end
        end
    endtask

    task automatic test_reset_mid();
        int d0;
        bit to = 1'b1;
        load_t1_regs();
        rdy_rand = 1'b0;
        clear_mon();
        start_a = 1'b1;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (got_q.size() >= 8) begin
                to = 1'b0;
                break;
            end
        end
        checks++; if (to) begin errors++; $display("FAIL t5_reach_byte7: only %0d bytes in 200 cycles", got_q.size()); end
        rst = 1'b1;
        #1;
        checks++; if (out_valid_a !== 1'b0 || out_data_a !== 8'h00) begin errors++; $display("FAIL t5_outputs_in_reset: valid %b data %h expected 0 00", out_valid_a, out_data_a); end
        checks++; if (addr_a !== 2'd0 || busy_a !== 1'b0) begin errors++; $display("FAIL t5_addr_busy_in_reset: addr %0d busy %b expected 0 0", addr_a, busy_a); end
        @(negedge clk12);
        rst = 1'b0;
        repeat (3) tick();
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL t5_no_resume: busy %b expected 0", busy_a); end
        clear_mon();
        d0 = done_cnt;
        start_a = 1'b1;
        wait_done(d0, 500, to);
        checks++; if (to) begin errors++; $display("FAIL t5_timeout: no done within 500 cycles"); end
        checks++; if (got_q.size() != 18) begin errors++; $display("FAIL t5_len: got %0d expected 18", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < 18; i++) begin
            checks++; if (got_q[i] !== T1_TBL[i]) begin errors++; $display("FAIL t5_byte[%0d]: got %h expected %h", i, got_q[i], T1_TBL[i]); end
        end
    endtask

    task automatic test_snapshot();
        int d0;
        bit to = 1'b1;
        bit changed = 1'b0;
        load_t1_regs();
        rdy_rand = 1'b0;
        clear_mon();
        d0 = done_cnt;
        start_a = 1'b1;
        for (int i = 0; i < 500; i++) begin
            tick();
            if (!changed && got_q.size() >= 10) begin
                regs[2] = 32'h00000000;
                changed = 1'b1;
            end
            if (done_cnt != d0) begin
                to = 1'b0;
                break;
            end
        end
        checks++; if (to) begin errors++; $display("FAIL t6_timeout: no done within 500 cycles"); end
        checks++; if (got_q.size() != 18) begin errors++; $display("FAIL t6_len: got %0d expected 18", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < 18; i++) begin
            checks++; if (got_q[i] !== T1_TBL[i]) begin errors++; $display("FAIL t6_byte[%0d]: got %h expected %h", i, got_q[i], T1_TBL[i]); end
        end
        load_t1_regs();
    endtask

    task automatic test_random();
        int d0;
        bit to;
        for (int f = 0; f < 4; f++) begin
            for (int r = 0; r < NR; r++) regs[r] = $urandom;
            build_exp(1'b0);
            rdy_rand = 1'b1;
            clear_mon();
            d0 = done_cnt;
            start_a = 1'b1;
            wait_done(d0, 2000, to);
            checks++; if (to) begin errors++; $display("FAIL rand%0d_timeout: no done within 2000 cycles", f); end
            checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rand%0d_len: got %0d expected %0d", f, got_q.size(), exp_q.size()); end
            for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
                checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand%0d_byte[%0d]: got %h expected %h", f, i, got_q[i], exp_q[i]); end
            end
            checks++; if (stab_viol != 0) begin errors++; $display("FAIL rand%0d_stability: got %0d violations expected 0", f, stab_viol); end
        end
        rdy_rand = 1'b0;
        checks++; if (max_addr > NR - 1) begin errors++; $display("FAIL addr_range: max %0d expected <= %0d", max_addr, NR - 1); end
    endtask

    initial begin
        rst         = 1'b1;
        start_a     = 1'b0;
        start_b     = 1'b0;
        out_ready_a = 1'b1;
        out_ready_b = 1'b1;
        load_t1_regs();
        test_reset();
        test_t1_lsb();
        test_msb_first();
        test_stall();
        test_repulse();
        test_reset_mid();
        test_snapshot();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
